// File: rtl/main_mem_responder.sv
// -----------------------------------------------------------------------------
// main_mem_responder
//
// Simple main-memory model that serves cache line fills (reads) and
// writebacks (writes), one line request at a time.
//
// A read waits LATENCY idle cycles after the request is accepted. It then
// streams LINE_WORDS beats from the line-aligned base, using a valid/ready
// handshake. A write takes LINE_WORDS qualified beats into the same aligned
// line. It then pulses wr_done for one cycle.
//
// Storage starts with word i holding i. The storage is never reset, so
// words written before a reset are kept.
//
// Optional feature (macro MEM_STATS_EN):
//   defined   -> rd_count / wr_count count completed line reads / writes,
//                saturating at 16'hFFFF.
//   undefined -> rd_count / wr_count are tied to 0 and no counter
//                registers exist.
//
// Ports
//   clk          in   single clock, rising edge
//   reset        in   asynchronous, active-low reset
//   req_valid    in   cache presents a line request
//   req_ready    out  request accepted this cycle (IDLE only)
//   req_rd_wr    in   0 = line fill (read), 1 = writeback (write)
//   req_addr     in   byte address; word index = req_addr[DEPTH_LOG2+1:2]
//   wdata        in   writeback beat
//   wdata_valid  in   writeback beat qualifier
//   rsp_data     out  read beat
//   rsp_valid    out  read beat qualifier
//   rsp_last     out  final read beat of the line
//   rsp_ready    in   cache accepts the current read beat
//   wr_done      out  one-cycle pulse when a writeback completes
//   rd_count     out  completed line reads  (MEM_STATS_EN)
//   wr_count     out  completed line writes (MEM_STATS_EN)
// -----------------------------------------------------------------------------
module main_mem_responder #(
  parameter int DATA_W     = 32,
  parameter int DEPTH_LOG2 = 10,
  parameter int LINE_WORDS = 4,
  parameter int LATENCY    = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_rd_wr,
  input  logic [31:0]       req_addr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              wdata_valid,
  output logic [DATA_W-1:0] rsp_data,
  output logic              rsp_valid,
  output logic              rsp_last,
  input  logic              rsp_ready,
  output logic              wr_done,
  output logic [15:0]       rd_count,
  output logic [15:0]       wr_count
);

  localparam int DEPTH  = 1 << DEPTH_LOG2;
  localparam int OFF_W  = $clog2(LINE_WORDS);
  localparam int LINE_W = DEPTH_LOG2 - OFF_W;
  localparam logic [OFF_W-1:0] LAST_BEAT = OFF_W'(LINE_WORDS - 1);

  typedef enum logic [2:0] {IDLE, WAIT, RD_BURST, WR_BURST, WR_ACK} state_t;

  state_t            state;
  logic [LINE_W-1:0] line;      // line-aligned base, stored without its zero offset bits
  logic [OFF_W-1:0]  beat;      // offset inside the line; wraps naturally, never leaves it
  logic [OFF_W-1:0]  beat_nxt;
  logic [7:0]        wait_cnt;

  assign beat_nxt = beat + 1'b1;

  // Address bits outside the word index are ignored, so memory aliases
  // modulo its size. The byte offset within a word is unused as well.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{req_addr[31:DEPTH_LOG2+2], req_addr[OFF_W+1:0]};

  function automatic logic [DEPTH-1:0][DATA_W-1:0] init_mem();
    logic [DEPTH-1:0][DATA_W-1:0] m;
    for (int i = 0; i < DEPTH; i++) m[i] = DATA_W'(i);
    return m;
  endfunction

  logic [DEPTH-1:0][DATA_W-1:0] mem = init_mem();

  // NOTE: the storage has no reset branch. A reset in the middle of a
  // writeback therefore keeps the words already written. While reset is low
  // the state is forced to IDLE, which blocks any further writes.
  always_ff @(posedge clk) begin
    if (state == WR_BURST && wdata_valid) mem[{line, beat}] <= wdata;
  end

  // NOTE: all state and registered outputs use non-blocking assignments, so
  // every branch sees the values from before this clock edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      req_ready <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_last  <= 1'b0;
      rsp_data  <= '0;
      wr_done   <= 1'b0;
      line      <= '0;
      beat      <= '0;
      wait_cnt  <= '0;
    end else begin
      case (state)
        IDLE: begin
          req_ready <= 1'b1;
          if (req_valid && req_ready) begin
            req_ready <= 1'b0;
            line      <= req_addr[DEPTH_LOG2+1 -: LINE_W];
            beat      <= '0;
            if (req_rd_wr) begin
              state <= WR_BURST;
            end else begin
              state    <= WAIT;
              wait_cnt <= 8'(LATENCY - 1);
            end
          end
        end

        WAIT: begin
          if (wait_cnt == '0) begin
            state     <= RD_BURST;
            rsp_valid <= 1'b1;
            rsp_last  <= 1'b0;
            rsp_data  <= mem[{line, beat}];
          end else begin
            wait_cnt <= wait_cnt - 1'b1;
          end
        end

        // rsp_data is only reloaded when a beat is accepted, so it holds
        // steady while the cache stalls.
        RD_BURST: begin
          if (rsp_ready) begin
            if (beat == LAST_BEAT) begin
              state     <= IDLE;
              req_ready <= 1'b1;
              rsp_valid <= 1'b0;
              rsp_last  <= 1'b0;
              rsp_data  <= '0;
            end else begin
              beat     <= beat_nxt;
              rsp_data <= mem[{line, beat_nxt}];
              rsp_last <= (beat_nxt == LAST_BEAT);
            end
          end
        end

        WR_BURST: begin
          if (wdata_valid) begin
            if (beat == LAST_BEAT) begin
              state   <= WR_ACK;
              wr_done <= 1'b1;
            end else begin
              beat <= beat_nxt;
            end
          end
        end

        WR_ACK: begin
          wr_done   <= 1'b0;
          state     <= IDLE;
          req_ready <= 1'b1;
        end

        default: state <= IDLE;
      endcase
    end
  end

`ifdef MEM_STATS_EN
  logic rd_line_done;
  logic wr_line_done;

  assign rd_line_done = (state == RD_BURST) && rsp_ready && (beat == LAST_BEAT);
  assign wr_line_done = (state == WR_BURST) && wdata_valid && (beat == LAST_BEAT);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_count <= '0;
      wr_count <= '0;
    end else begin
      if (rd_line_done && rd_count != 16'hFFFF) rd_count <= rd_count + 1'b1;
      if (wr_line_done && wr_count != 16'hFFFF) wr_count <= wr_count + 1'b1;
    end
  end
`else
  assign rd_count = '0;
  assign wr_count = '0;
`endif

endmodule
